// File: rtl/memc_dma_lane_responder_if.sv
// Signal bundle between one lane's DMA stream-0 port, its memory-controller
// responder and the single-port SRAM behind it.
interface memc_dma_lane_responder_if #(
    parameter int ADDR_WIDTH      = 24,
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 12
);
    logic                       dma__memc__write_valid;
    logic [ADDR_WIDTH-1:0]      dma__memc__write_address;
    logic [DATA_WIDTH-1:0]      dma__memc__write_data;
    logic                       memc__dma__write_ready;
    logic                       dma__memc__read_valid;
    logic [ADDR_WIDTH-1:0]      dma__memc__read_address;
    logic                       memc__dma__read_ready;
    logic                       dma__memc__read_pause;
    logic [DATA_WIDTH-1:0]      memc__dma__read_data;
    logic                       memc__dma__read_data_valid;
    logic                       memc__sys__addr_err;
    logic                       sram__we;
    logic                       sram__re;
    logic [SRAM_ADDR_WIDTH-1:0] sram__addr;
    logic [DATA_WIDTH-1:0]      sram__wdata;
    logic [DATA_WIDTH-1:0]      sram__rdata;

    modport slave (
        input  dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
        input  dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
        output memc__dma__write_ready, memc__dma__read_ready,
        output memc__dma__read_data, memc__dma__read_data_valid, memc__sys__addr_err,
        output sram__we, sram__re, sram__addr, sram__wdata,
        input  sram__rdata
    );

    modport master (
        output dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
        output dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
        input  memc__dma__write_ready, memc__dma__read_ready,
        input  memc__dma__read_data, memc__dma__read_data_valid, memc__sys__addr_err,
        input  sram__we, sram__re, sram__addr, sram__wdata,
        output sram__rdata
    );
endinterface

// File: rtl/memc_dma_lane_responder.sv
// Lane responder: arbitrates DMA reads/writes onto a fixed-latency single-port
// SRAM and returns read data in order through a credit-guarded FIFO.
module memc_dma_lane_responder #(
    parameter int ADDR_WIDTH      = 24,
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 12,
    parameter int READ_LATENCY    = 2,
    parameter int RDQ_DEPTH       = 8,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                       clk,
    input  logic                       reset_poweron,
    memc_dma_lane_responder_if.slave   bus
);
    localparam int PTR_W = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RDQ_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    function automatic logic addr_out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return |(addr >> SRAM_ADDR_WIDTH);
    endfunction

    logic                       r_live;
    logic                       r_wr_force;
    logic                       r_addr_err;
    logic [CNT_W-1:0]           r_inflight;
    logic [CNT_W-1:0]           r_count;
    logic [PTR_W-1:0]           r_wptr;
    logic [PTR_W-1:0]           r_rptr;
    logic [DATA_WIDTH-1:0]      r_fifo [RDQ_DEPTH];
    logic [READ_LATENCY-1:0]    r_vld_sr;
    logic [STV_W-1:0]           r_starve_cnt;
    logic [SRAM_ADDR_WIDTH-1:0] r_sram_addr;
    logic [DATA_WIDTH-1:0]      r_sram_wdata;

    logic                       w_credit_ok;
    logic                       w_read_ready;
    logic                       w_write_ready;
    logic                       w_rd_acc;
    logic                       w_wr_acc;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_empty;
    logic                       w_acc_addr_bad;
    logic [STV_W-1:0]           w_starve_nxt;
    logic [SRAM_ADDR_WIDTH-1:0] w_sram_addr;
    logic [DATA_WIDTH-1:0]      w_sram_wdata;

    // Sum is kept in CNT_W bits; the credit invariant keeps it at or below RDQ_DEPTH.
    assign w_credit_ok    = (r_inflight + r_count) < DEPTH_C;
    assign w_read_ready   = r_live & w_credit_ok & ~r_wr_force;
    assign w_rd_acc       = bus.dma__memc__read_valid & w_read_ready;
    assign w_write_ready  = r_live & (~w_rd_acc | r_wr_force);
    assign w_wr_acc       = bus.dma__memc__write_valid & w_write_ready;
    assign w_push         = r_vld_sr[READ_LATENCY-1];
    assign w_empty        = (r_count == {CNT_W{1'b0}});
    assign w_pop          = ~w_empty & ~bus.dma__memc__read_pause;
    assign w_acc_addr_bad = (w_wr_acc & addr_out_of_range(bus.dma__memc__write_address))
                          | (w_rd_acc & addr_out_of_range(bus.dma__memc__read_address));

    // Starvation count: grows per read grant that leaves a pending write blocked
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_wr_acc || !bus.dma__memc__write_valid) begin
            w_starve_nxt = {STV_W{1'b0}};
        end else if (w_rd_acc && (r_starve_cnt != LIMIT_C)) begin
            w_starve_nxt = r_starve_cnt + STV_W'(1'b1);
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    // SRAM address/data mux; idle cycles hold the last driven values
    always_comb begin
        w_sram_addr  = r_sram_addr;
        w_sram_wdata = r_sram_wdata;
        if (w_wr_acc) begin
            w_sram_addr  = bus.dma__memc__write_address[SRAM_ADDR_WIDTH-1:0];
            w_sram_wdata = bus.dma__memc__write_data;
        end else if (w_rd_acc) begin
            w_sram_addr  = bus.dma__memc__read_address[SRAM_ADDR_WIDTH-1:0];
        end else begin
            w_sram_addr  = r_sram_addr;
        end
    end

    // Control state: liveness, arbitration, credit counters, pointers, error flag
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_live       <= 1'b0;
            r_wr_force   <= 1'b0;
            r_addr_err   <= 1'b0;
            r_inflight   <= {CNT_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_wptr       <= {PTR_W{1'b0}};
            r_rptr       <= {PTR_W{1'b0}};
            r_vld_sr     <= {READ_LATENCY{1'b0}};
            r_starve_cnt <= {STV_W{1'b0}};
            r_sram_addr  <= {SRAM_ADDR_WIDTH{1'b0}};
            r_sram_wdata <= {DATA_WIDTH{1'b0}};
        end else begin
            r_live       <= 1'b1;
            r_wr_force   <= (w_starve_nxt == LIMIT_C);
            r_starve_cnt <= w_starve_nxt;
            r_addr_err   <= r_addr_err | w_acc_addr_bad;
            r_vld_sr     <= (r_vld_sr << 1'b1) | READ_LATENCY'(w_rd_acc);
            r_inflight   <= r_inflight + CNT_W'(w_rd_acc) - CNT_W'(w_push);
            r_count      <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_sram_addr  <= w_sram_addr;
            r_sram_wdata <= w_sram_wdata;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1'b1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1'b1);
            end
        end
    end

    // Return FIFO storage; contents are qualified by r_count so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= bus.sram__rdata;
        end
    end

    assign bus.memc__dma__read_ready      = w_read_ready;
    assign bus.memc__dma__write_ready     = w_write_ready;
    assign bus.memc__dma__read_data_valid = w_pop;
    assign bus.memc__dma__read_data       = w_empty ? {DATA_WIDTH{1'b0}} : r_fifo[r_rptr];
    assign bus.memc__sys__addr_err        = r_addr_err;
    assign bus.sram__we                   = w_wr_acc;
    assign bus.sram__re                   = w_rd_acc;
    assign bus.sram__addr                 = w_sram_addr;
    assign bus.sram__wdata                = w_sram_wdata;
endmodule

// File: tb/tb_memc_dma_lane_responder.sv
// Directed bench for memc_dma_lane_responder: vector table plus hand sequences
// for backpressure, FIFO wrap, contention, address error and mid-flight reset.
module tb_memc_dma_lane_responder;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    memc_dma_lane_responder_if #(.ADDR_WIDTH(24), .DATA_WIDTH(32), .SRAM_ADDR_WIDTH(12)) bus ();

    memc_dma_lane_responder #(
        .ADDR_WIDTH(24), .DATA_WIDTH(32), .SRAM_ADDR_WIDTH(12),
        .READ_LATENCY(2), .RDQ_DEPTH(8), .STARVE_LIMIT(4)
    ) dut (
        .clk           (clk),
        .reset_poweron (rst_n),
        .bus           (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle read latency SRAM model
    logic [31:0] mem [4096];
    logic [31:0] s1;
    always @(posedge clk) begin
        if (bus.sram__we) mem[bus.sram__addr] <= bus.sram__wdata;
        if (bus.sram__re) s1 <= mem[bus.sram__addr];
        bus.sram__rdata <= s1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic        wv;
        logic [23:0] wa;
        logic [31:0] wd;
        logic        rv;
        logic [23:0] ra;
        logic        ps;
        logic        wrdy;
        logic        rrdy;
        logic        we;
        logic        re;
        logic [11:0] addr;
        logic        dv;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [13];

    task automatic set_in(input logic wv, input logic [23:0] wa, input logic [31:0] wd,
                          input logic rv, input logic [23:0] ra, input logic ps);
        bus.dma__memc__write_valid   = wv;
        bus.dma__memc__write_address = wa;
        bus.dma__memc__write_data    = wd;
        bus.dma__memc__read_valid    = rv;
        bus.dma__memc__read_address  = ra;
        bus.dma__memc__read_pause    = ps;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_one(input logic [23:0] ra, input logic [31:0] exp, input string name);
        logic got;
        got = 1'b0;
        set_in(1'b0, 24'h0, 32'h0, 1'b1, ra, 1'b0);
        sample();
        chk({name, "_issue"}, 64'(bus.sram__re), 64'd1);
        next_cyc();
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            sample();
            if (!got && bus.memc__dma__read_data_valid) begin
                got = 1'b1;
                chk(name, 64'(bus.memc__dma__read_data), 64'(exp));
            end
            next_cyc();
        end
        chk({name, "_seen"}, 64'(got), 64'd1);
    endtask

    initial begin
        int          acc;
        int          stale;
        logic        rr_last;

        n_chk = 0;
        n_err = 0;
        // {wv, wa, wd, rv, ra, ps, wrdy, rrdy, we, re, addr, dv, data}
        vecs[0]  = '{1'b1, 24'h000005, 32'hDEADBEEF, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h005, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 24'h0, 32'h0, 1'b1, 24'h000005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h005, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h005, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h005, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h005, 1'b1, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h005, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 24'h0000FF, 32'hCAFEF00D, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h0FF, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 24'h0, 32'h0, 1'b1, 24'h0000FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h0FF, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0FF, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0FF, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0FF, 1'b0, 32'hCAFEF00D};
        vecs[11] = '{1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0FF, 1'b1, 32'hCAFEF00D};
        vecs[12] = '{1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0FF, 1'b0, 32'h0};

        // Reset with requests pending: everything must stay quiet
        rst_n = 1'b0;
        set_in(1'b1, 24'h000123, 32'h11111111, 1'b1, 24'h000456, 1'b0);
        repeat (3) @(posedge clk);
        sample();
        chk("reset_ctrl", 64'({bus.memc__dma__write_ready, bus.memc__dma__read_ready, bus.sram__we,
                               bus.sram__re, bus.memc__dma__read_data_valid, bus.memc__sys__addr_err,
                               bus.sram__addr}), 64'd0);
        chk("reset_data", 64'({bus.sram__wdata, bus.memc__dma__read_data}), 64'd0);
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0);
        #2 rst_n = 1'b1;
        #1 chk("release_not_live", 64'(bus.memc__dma__read_ready), 64'd0);
        next_cyc();

        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra, vecs[i].ps);
            sample();
            chk($sformatf("vec%0d", i),
                64'({bus.memc__dma__write_ready, bus.memc__dma__read_ready, bus.sram__we, bus.sram__re,
                     bus.sram__addr, bus.memc__dma__read_data_valid, bus.memc__dma__read_data}),
                64'({vecs[i].wrdy, vecs[i].rrdy, vecs[i].we, vecs[i].re,
                     vecs[i].addr, vecs[i].dv, vecs[i].data}));
            next_cyc();
        end

        // Preload 0x010..0x017 with A-pattern and 0x020..0x028 with B-pattern
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 24'(24'h10 + i), 32'(32'hA0000000 + i), 1'b0, 24'h0, 1'b0);
            next_cyc();
        end
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 24'(24'h20 + i), 32'(32'hB0000000 + i), 1'b0, 24'h0, 1'b0);
            next_cyc();
        end

        // 16 read attempts under pause: only RDQ_DEPTH get credit
        acc = 0;
        rr_last = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_in(1'b0, 24'h0, 32'h0, 1'b1, 24'(24'h10 + acc), 1'b1);
            sample();
            if (bus.sram__re) acc++;
            if (i == 15) rr_last = bus.memc__dma__read_ready;
            next_cyc();
        end
        chk("pause_accepts", 64'(acc), 64'd8);
        chk("pause_ready_low", 64'(rr_last), 64'd0);
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            sample();
            chk($sformatf("drainA%0d", i), 64'({bus.memc__dma__read_data_valid, bus.memc__dma__read_data}),
                64'({1'b1, 32'(32'hA0000000 + i)}));
            next_cyc();
        end
        sample();
        chk("drainA_ready_back", 64'({bus.memc__dma__read_ready, bus.memc__dma__read_data_valid}), 64'b10);
        next_cyc();

        // Fill FIFO to 7, then push and pop together across the index 7->0 wrap
        acc = 0;
        for (int i = 0; i < 20 && acc < 7; i++) begin
            set_in(1'b0, 24'h0, 32'h0, 1'b1, 24'(24'h20 + acc), 1'b1);
            sample();
            if (bus.sram__re) acc++;
            next_cyc();
        end
        chk("fill7_accepts", 64'(acc), 64'd7);
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b1);
        repeat (3) next_cyc();
        set_in(1'b0, 24'h0, 32'h0, 1'b1, 24'h27, 1'b1);
        sample();
        chk("fill7_issue8", 64'(bus.sram__re), 64'd1);
        next_cyc();
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b1);
        sample();
        chk("fill7_no_credit", 64'(bus.memc__dma__read_ready), 64'd0);
        next_cyc();
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0);
        sample();
        chk("pushpop_beat", 64'({bus.memc__dma__read_data_valid, bus.memc__dma__read_data}),
            64'({1'b1, 32'hB0000000}));
        next_cyc();
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b1);
        sample();
        chk("pushpop_count7", 64'(bus.memc__dma__read_ready), 64'd1);
        next_cyc();
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            sample();
            chk($sformatf("drainB%0d", i), 64'({bus.memc__dma__read_data_valid, bus.memc__dma__read_data}),
                64'({1'b1, 32'(32'hB0000000 + i)}));
            next_cyc();
        end
        sample();
        chk("drainB_empty", 64'(bus.memc__dma__read_data_valid), 64'd0);
        next_cyc();
        read_one(24'h000028, 32'hB0000008, "wrap_read");

        // Both valids held: four reads then one forced write, repeating
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 24'h000030, 32'(32'h5A5A0000 + i), 1'b1, 24'h000005, 1'b0);
            sample();
            chk($sformatf("contend%0d", i), 64'({bus.sram__we, bus.sram__re}),
                ((i % 5) == 4) ? 64'b10 : 64'b01);
            next_cyc();
        end
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0);
        repeat (4) next_cyc();

        // Out-of-range address: truncated access, sticky flag
        sample();
        chk("aerr_before", 64'(bus.memc__sys__addr_err), 64'd0);
        next_cyc();
        set_in(1'b0, 24'h0, 32'h0, 1'b1, 24'h001005, 1'b0);
        sample();
        chk("aerr_trunc_addr", 64'({bus.sram__re, bus.sram__addr}), 64'({1'b1, 12'h005}));
        next_cyc();
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0);
        sample();
        chk("aerr_set", 64'(bus.memc__sys__addr_err), 64'd1);
        next_cyc();
        sample();
        next_cyc();
        sample();
        chk("aerr_data", 64'({bus.memc__dma__read_data_valid, bus.memc__dma__read_data}),
            64'({1'b1, 32'hDEADBEEF}));
        next_cyc();
        repeat (3) next_cyc();
        sample();
        chk("aerr_sticky", 64'(bus.memc__sys__addr_err), 64'd1);
        next_cyc();

        // Two entries parked in the FIFO, then reads in flight when reset hits
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 24'h0, 32'h0, 1'b1, 24'(24'h10 + i), 1'b1);
            next_cyc();
        end
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b1);
        repeat (3) next_cyc();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 24'h0, 32'h0, 1'b1, 24'(24'h12 + i), 1'b1);
            next_cyc();
        end
        set_in(1'b0, 24'h0, 32'h0, 1'b1, 24'h14, 1'b1);
        sample();
        chk("mid_third_issue", 64'(bus.sram__re), 64'd1);
        #1 rst_n = 1'b0;
        set_in(1'b0, 24'h0, 32'h0, 1'b0, 24'h0, 1'b0);
        #1;
        chk("midrst_ctrl", 64'({bus.memc__dma__write_ready, bus.memc__dma__read_ready, bus.sram__we,
                                bus.sram__re, bus.memc__dma__read_data_valid, bus.memc__sys__addr_err,
                                bus.sram__addr}), 64'd0);
        chk("midrst_data", 64'({bus.sram__wdata, bus.memc__dma__read_data}), 64'd0);
        repeat (2) @(posedge clk);
        sample();
        #2 rst_n = 1'b1;
        #1 chk("midrst_release_not_live", 64'(bus.memc__dma__read_ready), 64'd0);
        next_cyc();
        sample();
        chk("midrst_ready_back", 64'(bus.memc__dma__read_ready), 64'd1);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.memc__dma__read_data_valid) stale++;
            next_cyc();
            sample();
        end
        chk("midrst_no_stale", 64'(stale), 64'd0);
        next_cyc();
        read_one(24'h000005, 32'hDEADBEEF, "post_reset_read");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
